// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel total-gradient stage.
package sobel_pkg;

  typedef enum logic [1:0] {IDLE, CALC, OUT} grad_seq_state_t;

  localparam int GRAD_W = 11;
  localparam int PIX_W  = 8;
  localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

  // Any bit above the pixel width means the sum exceeds the pixel range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic [GRAD_W:0] sum);
    return (|sum[GRAD_W:PIX_W]) ? PIX_MAX : sum[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/total_gradient.sv
// Combinational total-gradient datapath: g = min(gx+gy, 255), forced to 0 unless enabled.
module total_gradient
  import sobel_pkg::*;
(
  input  logic              start_t_grad,
  input  logic [GRAD_W-1:0] gx,
  input  logic [GRAD_W-1:0] gy,
  output logic [PIX_W-1:0]  g
);

  logic [GRAD_W:0] w_sum;

  assign w_sum = {1'b0, gx} + {1'b0, gy};
  assign g     = start_t_grad ? sat_pix(w_sum) : '0;

endmodule

// File: rtl/gradient_sequencer.sv
// Sequencer for the total-gradient stage: operand capture, magnitude register, row/col tracking.
// Optional build macro GRAD_THRESH_EN binarizes the pixel against the threshold port.
//
//   state | meaning
//   IDLE  | waiting for a gx/gy pair
//   CALC  | datapath enabled, magnitude captured at the edge
//   OUT   | pixel presented, waiting for downstream accept
module gradient_sequencer
  import sobel_pkg::*;
#(
  parameter  int IMG_W = 640,
  parameter  int IMG_H = 480,
  localparam int ROW_W = $clog2(IMG_H),
  localparam int COL_W = $clog2(IMG_W)
)
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GRAD_W-1:0] gx,
  input  logic [GRAD_W-1:0] gy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  pix,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
`ifdef GRAD_THRESH_EN
  input  logic [PIX_W-1:0]  threshold,
`endif
  output logic              frame_done,
  output logic              busy
);

  grad_seq_state_t r_state, w_next_state;

  logic [GRAD_W-1:0] r_gx, r_gy;
  logic [PIX_W-1:0]  r_pix, w_g, w_pix_next;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic              r_frame_done;
  logic              w_start, w_load, w_out_hs;
  logic              w_col_last, w_row_last;

  total_gradient u_total_gradient (
    .start_t_grad (w_start),
    .gx           (r_gx),
    .gy           (r_gy),
    .g            (w_g)
  );

`ifdef GRAD_THRESH_EN
  assign w_pix_next = (w_g >= threshold) ? PIX_MAX : '0;
`else
  assign w_pix_next = w_g;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // in_ready in OUT follows out_ready so a new pair can ride the output handshake.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_out_hs     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = n_rst;
        if (in_valid && n_rst) begin
          w_load       = 1'b1;
          w_next_state = CALC;
        end
      end
      CALC: begin
        w_start      = 1'b1;
        w_next_state = OUT;
      end
      OUT: begin
        in_ready = out_ready;
        if (out_ready) begin
          w_out_hs = 1'b1;
          if (in_valid) begin
            w_load       = 1'b1;
            w_next_state = CALC;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_gx         <= '0;
      r_gy         <= '0;
      r_pix        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_load) begin
        r_gx <= gx;
        r_gy <= gy;
      end
      if (w_start) r_pix <= w_pix_next;
      if (w_out_hs) begin
        if (w_col_last) begin
          r_col <= '0;
          if (w_row_last) begin
            r_row        <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign out_valid  = (r_state == OUT);
  assign busy       = (r_state != IDLE);
  assign pix        = r_pix;
  assign row        = r_row;
  assign col        = r_col;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_gradient_sequencer.sv
// Bench for gradient_sequencer (IMG_W=4, IMG_H=2): transaction-level model plus directed literal checks.
module tb_gradient_sequencer;
  import sobel_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int FR = W * H;

`ifdef GRAD_THRESH_EN
  localparam int E34 = 0, E12_13 = 0, E1_1 = 0, E24_106 = 255;
`else
  localparam int E34 = 7, E12_13 = 25, E1_1 = 2, E24_106 = 130;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [GRAD_W-1:0] gx = '0;
  logic [GRAD_W-1:0] gy = '0;
`ifdef GRAD_THRESH_EN
  logic [PIX_W-1:0] threshold = 8'd100;
`endif
  logic in_ready, out_valid, frame_done, busy;
  logic [PIX_W-1:0] pix;
  logic [$clog2(H)-1:0] row;
  logic [$clog2(W)-1:0] col;

  always #5 clk = ~clk;

  gradient_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .gx         (gx),
    .gy         (gy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pix        (pix),
    .row        (row),
    .col        (col),
`ifdef GRAD_THRESH_EN
    .threshold  (threshold),
`endif
    .frame_done (frame_done),
    .busy       (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a queue of accepted pairs, each visible one edge after its accept edge.
  typedef struct { logic [7:0] p; int rdy; } ent_t;
  ent_t q[$];
  int  cyc = 0;
  int  n_out = 0;
  bit  fd_exp = 0;
  bit  m_v, m_hs, m_acc, c_v;

  function automatic logic [7:0] model_pix(input int a, input int b);
    int s;
    s = a + b;
    if (s > 255) s = 255;
`ifdef GRAD_THRESH_EN
    return (s >= int'(threshold)) ? 8'd255 : 8'd0;
`else
    return 8'(s);
`endif
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q.delete();
      n_out  = 0;
      fd_exp = 0;
    end else begin
      m_v   = (q.size() > 0) && (cyc >= q[0].rdy);
      m_hs  = m_v && out_ready;
      m_acc = in_valid && ((q.size() == 0) || m_hs);
      cyc++;
      fd_exp = 0;
      if (m_hs) begin
        void'(q.pop_front());
        if (n_out % FR == FR - 1) fd_exp = 1;
        n_out++;
      end
      if (m_acc) q.push_back('{model_pix(int'(gx), int'(gy)), cyc + 1});
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      c_v = (q.size() > 0) && (cyc >= q[0].rdy);
      chk("out_valid", out_valid, c_v);
      chk("busy", busy, q.size() > 0);
      chk("in_ready", in_ready, (q.size() == 0) || (c_v && out_ready));
      chk("frame_done", frame_done, fd_exp);
      if (c_v) begin
        chk("pix", pix, q[0].p);
        chk("row", row, (n_out / W) % H);
        chk("col", col, n_out % W);
      end
    end
  end

  // Handshake/frame_done recorder for the frame-wrap run.
  bit rec_en = 0;
  int nc = 0, hs_cnt = 0, fd_cnt = 0, fd_nc = -1;
  int hs_row[16], hs_col[16], hs_nc[16];

  always @(negedge clk) begin
    if (rec_en && n_rst) begin
      nc++;
      if (out_valid && out_ready && hs_cnt < 16) begin
        hs_row[hs_cnt] = row;
        hs_col[hs_cnt] = col;
        hs_nc[hs_cnt]  = nc;
        hs_cnt++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_nc = nc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b);
    int i;
    gx = GRAD_W'(a);
    gy = GRAD_W'(b);
    in_valid = 1'b1;
    #1;
    i = 0;
    while (!in_ready && i < 20) begin
      step();
      i++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic pixel(input int a, input int b, input int ep, input int er, input int ec,
                       input string nm);
    int lat;
    out_ready = 1'b1;
    send(a, b);
    wait_out(lat);
    chk({nm, "_latency"}, lat + 1, 2);
    chk({nm, "_pix"}, pix, ep);
    chk({nm, "_row"}, row, er);
    chk({nm, "_col"}, col, ec);
    step();
    chk({nm, "_done_valid"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pix", pix, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    n_rst = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    pixel(3, 4, E34, 0, 0, "first");
    pixel(200, 95, 255, 0, 1, "sat_a");
    pixel(0, 0, 0, 0, 2, "zero");
    pixel(55, 555, 255, 0, 3, "sat_b");

    // Backpressure with a second pair waiting at the input.
    out_ready = 1'b0;
    send(12, 13);
    wait_out(lat);
    gx = 11'd1;
    gy = 11'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_pix", pix, E12_13);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_row", row, 1);
      chk("bp_col", col, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_after_hs_valid", out_valid, 0);
    chk("bp_after_hs_col", col, 1);
    step();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_pix", pix, E1_1);
    chk("bp_next_col", col, 1);
    step();

    // Reset while a pixel is stalled in OUT.
    out_ready = 1'b0;
    send(24, 106);
    wait_out(lat);
    chk("mid_pix_before", pix, E24_106);
    n_rst = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_pix", pix, 0);
    chk("mid_row", row, 0);
    chk("mid_col", col, 0);
    chk("mid_busy", busy, 0);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_frame_done", frame_done, 0);
    step();
    n_rst = 1'b1;
    pixel(3, 4, E34, 0, 0, "post_rst");

    // Frame wrap: 9 streamed pairs over a 4x2 frame.
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    out_ready = 1'b1;
    rec_en = 1'b1;
    for (int k = 0; k < 9; k++) send(k * 10, 5);
    wait_out(lat);
    step();
    repeat (3) step();
    rec_en = 1'b0;
    chk("fw_hs_count", hs_cnt, 9);
    chk("fw_hs0_row", hs_row[0], 0);
    chk("fw_hs0_col", hs_col[0], 0);
    chk("fw_hs3_col", hs_col[3], 3);
    chk("fw_hs4_row", hs_row[4], 1);
    chk("fw_hs4_col", hs_col[4], 0);
    chk("fw_hs7_row", hs_row[7], 1);
    chk("fw_hs7_col", hs_col[7], 3);
    chk("fw_hs8_row", hs_row[8], 0);
    chk("fw_hs8_col", hs_col[8], 0);
    chk("fw_rate_a", hs_nc[1] - hs_nc[0], 2);
    chk("fw_rate_b", hs_nc[8] - hs_nc[7], 2);
    chk("fw_fd_count", fd_cnt, 1);
    chk("fw_fd_when", fd_nc, hs_nc[7] + 1);

`ifdef GRAD_THRESH_EN
    pixel(24, 106, 255, 0, 1, "thr_a");
    pixel(3, 4, 0, 0, 2, "thr_b");
    pixel(50, 50, 255, 0, 3, "thr_c");
`endif

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
